// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: opcode constants, bubble word, FSM encoding, IF/ID record.
package fetch_stage_pkg;

    typedef logic [15:0] word_t;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

    localparam word_t NOP_INSTR_DEFAULT = {OP_NOP, 11'd0};

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetchState_t;

    typedef struct packed {
        word_t instr;
        word_t nextPc;
        logic  valid;
    } ifId_t;

    function automatic logic isHalt(input logic [4:0] opcode);
        return opcode == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: redirect/stall in, imem request/response, IF/ID outputs.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic  stall;
    logic  doBranch;
    word_t jumpPc;
    word_t imemData;
    logic  imemDone;
    logic  imemRd;
    word_t imemAddr;
    word_t instrOut;
    word_t nextPcOut;
    logic  valid;
    logic  halted;
    logic  err;

    modport master (
        input  stall, doBranch, jumpPc, imemData, imemDone,
        output imemRd, imemAddr, instrOut, nextPcOut, valid, halted, err
    );

    modport slave (
        output stall, doBranch, jumpPc, imemData, imemDone,
        input  imemRd, imemAddr, instrOut, nextPcOut, valid, halted, err
    );
endinterface

// File: rtl/fetch_stage_cla.sv
// 16-bit two-level carry-lookahead adder (4-bit groups), used for the PC increment.
module cla16Bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum
);
    logic [15:0] g, p, c;
    logic [2:0]  gg, pp;
    logic [3:0]  gc;

    assign g = A & B;
    assign p = A ^ B;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : grp
            if (k < 3) begin : gp
                assign gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                             | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                             | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
                assign pp[k] = &p[4*k +: 4];
            end
            assign c[4*k]   = gc[k];
            assign c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                            | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
    endgenerate

    // Group carries resolved in parallel from group generate/propagate.
    assign gc[0] = Cin;
    assign gc[1] = gg[0] | (pp[0] & Cin);
    assign gc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & Cin);
    assign gc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & Cin);

    assign Sum = p ^ c;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a variable-latency imem, loads the IF/ID register.
// Latency: IF/ID loads on the edge where imemDone is seen; zero-wait memory gives one instr per cycle.
// Backpressure: stall freezes PC and IF/ID; a word returning under stall parks in a skid register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC  = 16'h0000,
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    fetchState_t state, stateNext;
    word_t       pc, pcPlus2, sqAddr, skid, loadWord, imemAddr;
    logic        squash, errReg, imemRd, takeWord, loadIfId;
    ifId_t       ifId;

    cla16Bit pcAdder (.A(pc), .B(16'h0002), .Cin(1'b0), .Sum(pcPlus2));

    assign imemRd   = rst && (state == ST_FETCH || state == ST_WAIT);
    assign imemAddr = squash ? sqAddr : pc;
    assign takeWord = bus.imemDone && imemRd && !squash && !bus.doBranch;
    assign loadWord = (state == ST_HOLD) ? skid : bus.imemData;
    assign loadIfId = !bus.stall && (takeWord || state == ST_HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_FETCH;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_FETCH, ST_WAIT: begin
                if (takeWord)
                    stateNext = bus.stall ? ST_HOLD
                              : (isHalt(bus.imemData[15:11]) ? ST_HALTED : ST_FETCH);
                else if (bus.imemDone)
                    stateNext = ST_FETCH;
                else
                    stateNext = ST_WAIT;
            end
            ST_HOLD:   if (!bus.stall) stateNext = isHalt(skid[15:11]) ? ST_HALTED : ST_FETCH;
            ST_HALTED: stateNext = ST_HALTED;
            default:   stateNext = ST_FETCH;
        endcase
        if (bus.doBranch) stateNext = ST_FETCH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            squash <= 1'b0;
            sqAddr <= '0;
            skid   <= '0;
            errReg <= 1'b0;
            ifId   <= '{instr: NOP_INSTR, nextPc: '0, valid: 1'b0};
        end else begin
            if ((bus.doBranch && bus.jumpPc[0]) || (bus.imemDone && !imemRd))
                errReg <= 1'b1;
            if (bus.doBranch) begin
                // An in-flight read keeps its address on the bus until its done is swallowed.
                pc     <= {bus.jumpPc[15:1], 1'b0};
                squash <= imemRd && !bus.imemDone;
                sqAddr <= imemAddr;
                ifId   <= '{instr: NOP_INSTR, nextPc: ifId.nextPc, valid: 1'b0};
            end else begin
                if (bus.imemDone) squash <= 1'b0;
                if (takeWord && bus.stall) skid <= bus.imemData;
                if (loadIfId) begin
                    ifId <= '{instr: loadWord, nextPc: pcPlus2, valid: 1'b1};
                    pc   <= pcPlus2;
                end else if (!bus.stall) begin
                    ifId <= '{instr: NOP_INSTR, nextPc: ifId.nextPc, valid: 1'b0};
                end
            end
        end
    end

    assign bus.imemRd    = imemRd;
    assign bus.imemAddr  = imemAddr;
    assign bus.instrOut  = ifId.instr;
    assign bus.nextPcOut = ifId.nextPc;
    assign bus.valid     = ifId.valid;
    assign bus.halted    = (state == ST_HALTED);
    assign bus.err       = errReg;
endmodule
